bus_slave_arbiter: RTL and testbench
====================================

// Module: bus_slave_arbiter
// PURPOSE
//  Round-robin arbiter that shares one cross-bar slave port between N_MASTERS
//  bus masters. Grants one master at a time and muxes its request onto the
//  slave. Holds the grant until the write is acked or the read response returns.
//  Bounds every phase with a timeout, so a dead slave cannot lock the cross bar.
// PARAMETERS
//  N_MASTERS  2    number of requesting masters (>=2)
//  AW         32   address width (bus_if_pkg::AW)
//  DW         32   data width (bus_if_pkg::DW)
//  TIMEOUT    255  max cycles waiting for s_ack or s_resp; 0 = no timeout
// PORTS
//  clk       in   1            system clock, all logic on rising edge
//  rst       in   1            synchronous reset, active-high
//  m_req     in   N_MASTERS    per-master request, held until m_ack
//  m_cmd     in   N_MASTERS    per-master command: 1=write, 0=read
//  m_addr    in   N_MASTERS*AW per-master address, master i at [i*AW +: AW]
//  m_wdata   in   N_MASTERS*DW per-master write data, [i*DW +: DW]
//  m_ack     out  N_MASTERS    one-cycle request-accepted pulse
//  m_resp    out  N_MASTERS    one-cycle read-data-valid pulse
//  m_err     out  N_MASTERS    one-cycle timeout flag, coincident with ack/resp
//  m_rdata   out  DW           read data, shared by all masters
//  s_req     out  1            request to slave
//  s_cmd     out  1            command to slave
//  s_addr    out  AW           address to slave
//  s_wdata   out  DW           write data to slave
//  s_ack     in   1            slave accepted the request
//  s_resp    in   1            slave read data valid
//  s_rdata   in   DW           slave read data
//  grant_id  out  clog2(N)     index of the current/last granted master
// BEHAVIOUR
//  FSM states: IDLE, REQ, RESP. Registers: state, gnt, rr_last, tmo_cnt.
//  IDLE:
//   - If any m_req is high, grant the first requester scanning from
//     rr_last+1 with wrap-around. Set gnt=rr_last=that index; go to REQ.
//   - Grant latency is 1 cycle: m_req seen high at edge t gives s_req=1
//     after edge t.
//  REQ:
//   - s_req=1. s_cmd, s_addr and s_wdata are combinationally muxed from
//     master gnt; masters hold them stable while m_req is high.
//   - m_ack[gnt] = s_ack in the same cycle (combinational).
//   - On s_ack, go to IDLE if the command is a write, to RESP if a read.
//  RESP:
//   - s_req=0. m_resp[gnt] = s_resp in the same cycle.
//   - m_rdata = s_rdata while in RESP, else 0. On s_resp, go to IDLE.
//  Timeout:
//   - tmo_cnt clears on every state entry and increments each cycle in
//     REQ or RESP.
//   - When tmo_cnt==TIMEOUT-1 and no s_ack or s_resp arrives, force
//     completion: in REQ pulse m_ack[gnt] and m_err[gnt]; in RESP pulse
//     m_resp[gnt] and m_err[gnt] with m_rdata=0. Then go to IDLE.
//   - If s_ack or s_resp arrives in that same cycle, it wins and m_err
//     stays 0.
//   - tmo_cnt width is $clog2(TIMEOUT+1).
//  Ordering and protocol rules:
//   - At least one IDLE cycle between transactions, so s_req is low for
//     >=1 cycle between grants.
//   - Masters drop m_req on the edge after m_ack. A master dropping m_req
//     in REQ does not abort the transaction.
//   - s_ack outside REQ and s_resp outside RESP are ignored.
//  Reset:
//   - state=IDLE, rr_last=N_MASTERS-1 (master 0 wins first), gnt=0,
//     tmo_cnt=0.
//   - All outputs are 0.
//   - Reset mid-transaction aborts silently: no ack, resp or err is issued.
// TESTING
//  1 Single write: m0 write addr=0x10 wdata=0xA5, slave acks 2 cycles
//    after s_req -> s_addr=0x10, m_ack[0] one cycle, s_req lasts 3 cycles.
//  2 Read: m1 read addr=0x20, s_resp 3 cycles after ack with s_rdata=0x1234
//    -> m_resp[1]=1 with m_rdata=0x1234, m_err=0.
//  3 Contention: m0 and m1 request continuously after reset -> grants
//    alternate 0,1,0,1, with one idle cycle between s_req pulses.
//  4 Timeout: TIMEOUT=4, slave never acks -> m_ack[0]=m_err[0]=1 on the 4th
//    REQ cycle, then IDLE; a read with no s_resp gets m_resp+m_err and
//    m_rdata=0.
//  5 Boundary: s_ack in the timeout cycle -> m_err=0. rst pulse during RESP
//    -> no m_resp, next grant goes to master 0.

Source files
------------

// File: rtl/bus_slave_arbiter.sv
// Round-robin arbiter sharing one slave port between N_MASTERS bus masters.
// One transaction is in flight at a time. The grant is held until the write
// is acked or the read data returns. Every waiting phase is bounded by
// TIMEOUT, so a silent slave cannot hold the cross-bar forever.
module bus_slave_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS-1:0]          m_cmd,
  input  logic [N_MASTERS*AW-1:0]       m_addr,
  input  logic [N_MASTERS*DW-1:0]       m_wdata,
  output logic [N_MASTERS-1:0]          m_ack,
  output logic [N_MASTERS-1:0]          m_resp,
  output logic [N_MASTERS-1:0]          m_err,
  output logic [DW-1:0]                 m_rdata,
  output logic                          s_req,
  output logic                          s_cmd,
  output logic [AW-1:0]                 s_addr,
  output logic [DW-1:0]                 s_wdata,
  input  logic                          s_ack,
  input  logic                          s_resp,
  input  logic [DW-1:0]                 s_rdata,
  output logic [$clog2(N_MASTERS)-1:0]  grant_id
);

  localparam int IW = $clog2(N_MASTERS);
  // A zero TIMEOUT disables the watchdog; keep the counter at least 1 bit wide.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]   rr_last_q, rr_last_d;
  logic [CW-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic [AW-1:0]   addr_arr  [N_MASTERS];
  logic [DW-1:0]   wdata_arr [N_MASTERS];
  logic [IW-1:0]   rr_pick;
  logic            rr_found;
  logic            tmo_hit;

  // Split the flat per-master buses into arrays so the mux is a plain index.
  generate
    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
      assign addr_arr[gi]  = m_addr[gi*AW +: AW];
      assign wdata_arr[gi] = m_wdata[gi*DW +: DW];
    end
  endgenerate

  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt_q == TMO_LAST);

  // Round-robin scan: the nearest requester after rr_last wins. Scanning
  // from the farthest offset down lets the closest hit overwrite the rest.
  always_comb begin : rr_scan
    int idx;
    idx      = 0;
    rr_pick  = '0;
    rr_found = 1'b0;
    for (int k = N_MASTERS; k >= 1; k--) begin
      idx = (int'(rr_last_q) + k) % N_MASTERS;
      if (m_req[IW'(idx)]) begin
        rr_found = 1'b1;
        rr_pick  = IW'(idx);
      end
    end
  end

  // State register: reset aborts any transaction and makes master 0 next.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      rr_last_q <= IW'(N_MASTERS - 1);
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_last_q <= rr_last_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Next-state and output decode. Outputs are held at zero during reset so
  // a transaction cut short by reset never produces a stray ack/resp/err.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_last_d = rr_last_q;
    tmo_cnt_d = tmo_cnt_q;
    m_ack     = '0;
    m_resp    = '0;
    m_err     = '0;
    m_rdata   = '0;
    s_req     = 1'b0;
    s_cmd     = 1'b0;
    s_addr    = '0;
    s_wdata   = '0;
    grant_id  = gnt_q;

    if (rst) begin
      grant_id = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rr_found) begin
            gnt_d     = rr_pick;
            rr_last_d = rr_pick;
            tmo_cnt_d = '0;
            state_d   = ST_REQ;
          end
        end

        ST_REQ: begin
          s_req     = 1'b1;
          s_cmd     = m_cmd[gnt_q];
          s_addr    = addr_arr[gnt_q];
          s_wdata   = wdata_arr[gnt_q];
          tmo_cnt_d = tmo_cnt_q + CW'(1);
          if (s_ack) begin
            // A real ack beats a timeout landing in the same cycle.
            m_ack[gnt_q] = 1'b1;
            tmo_cnt_d    = '0;
            state_d      = m_cmd[gnt_q] ? ST_IDLE : ST_RESP;
          end else if (tmo_hit) begin
            m_ack[gnt_q] = 1'b1;
            m_err[gnt_q] = 1'b1;
            tmo_cnt_d    = '0;
            state_d      = ST_IDLE;
          end
        end

        ST_RESP: begin
          m_rdata       = s_rdata;
          m_resp[gnt_q] = s_resp;
          tmo_cnt_d     = tmo_cnt_q + CW'(1);
          if (s_resp) begin
            tmo_cnt_d = '0;
            state_d   = ST_IDLE;
          end else if (tmo_hit) begin
            // Forced completion carries no data.
            m_resp[gnt_q] = 1'b1;
            m_err[gnt_q]  = 1'b1;
            m_rdata       = '0;
            tmo_cnt_d     = '0;
            state_d       = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_slave_arbiter.sv
// Bench for bus_slave_arbiter: directed scenarios with literal expectations,
// then randomized masters/slave, all checked every cycle against a
// transaction-level model of the arbiter.
module tb_bus_slave_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam int IW = $clog2(N);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      m_req = '0;
  logic [N-1:0]      m_cmd = '0;
  logic [N*AW-1:0]   m_addr = '0;
  logic [N*DW-1:0]   m_wdata = '0;
  logic [N-1:0]      m_ack, m_resp, m_err;
  logic [DW-1:0]     m_rdata;
  logic              s_req, s_cmd;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic              s_ack = 1'b0;
  logic              s_resp = 1'b0;
  logic [DW-1:0]     s_rdata = '0;
  logic [IW-1:0]     grant_id;

  int n_vec = 0;
  int n_bad = 0;

  bus_slave_arbiter #(.N_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_resp(m_resp), .m_err(m_err), .m_rdata(m_rdata),
    .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic set_m(input int i, input bit cmd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_cmd[i]            = cmd;
    m_addr[i*AW +: AW]  = a;
    m_wdata[i*DW +: DW] = d;
  endtask

  // ---------------- reference model ----------------
  // One outstanding transaction: who owns it, whether it awaits the ack or
  // the read data, and how many cycles it has waited in that phase.
  bit mdl_busy   = 1'b0;
  bit mdl_data   = 1'b0;
  int mdl_owner  = 0;
  int mdl_wait   = 0;
  int mdl_last   = N - 1;
  int mdl_shown  = 0;

  // Compare process: runs 2 time units after every falling edge, when the
  // inputs for this cycle are settled, then advances the model one cycle.
  always @(negedge clk) begin : checker_proc
    logic [N-1:0]  e_ack, e_resp, e_err;
    logic [DW-1:0] e_rdata;
    bit            e_sreq;
    int            e_gid, best, bestd, d;
    #2;
    e_ack = '0; e_resp = '0; e_err = '0; e_rdata = '0; e_sreq = 1'b0;
    e_gid = mdl_shown;
    best = -1; bestd = N; d = 0;
    if (rst) begin
      e_gid     = 0;
      mdl_busy  = 1'b0;
      mdl_last  = N - 1;
      mdl_shown = 0;
    end else if (!mdl_busy) begin
      for (int i = 0; i < N; i++) begin
        if (m_req[i]) begin
          d = (i - mdl_last - 1 + 2 * N) % N;
          if (d < bestd) begin
            bestd = d;
            best  = i;
          end
        end
      end
      if (best >= 0) begin
        mdl_busy  = 1'b1;
        mdl_data  = 1'b0;
        mdl_wait  = 0;
        mdl_owner = best;
        mdl_last  = best;
        mdl_shown = best;
      end
    end else if (!mdl_data) begin
      e_sreq = 1'b1;
      if (s_ack) begin
        e_ack[mdl_owner] = 1'b1;
        if (m_cmd[mdl_owner]) mdl_busy = 1'b0;
        else begin
          mdl_data = 1'b1;
          mdl_wait = 0;
        end
      end else if (mdl_wait + 1 == TO) begin
        e_ack[mdl_owner] = 1'b1;
        e_err[mdl_owner] = 1'b1;
        mdl_busy = 1'b0;
      end else begin
        mdl_wait++;
      end
    end else begin
      e_rdata = s_rdata;
      e_resp[mdl_owner] = s_resp;
      if (s_resp) begin
        mdl_busy = 1'b0;
      end else if (mdl_wait + 1 == TO) begin
        e_resp[mdl_owner] = 1'b1;
        e_err[mdl_owner]  = 1'b1;
        e_rdata  = '0;
        mdl_busy = 1'b0;
      end else begin
        mdl_wait++;
      end
    end
    cmp("m_ack", m_ack, e_ack);
    cmp("m_resp", m_resp, e_resp);
    cmp("m_err", m_err, e_err);
    cmp("m_rdata", m_rdata, e_rdata);
    cmp("s_req", s_req, e_sreq);
    cmp("grant_id", grant_id, e_gid);
    if (e_sreq) begin
      cmp("s_cmd", s_cmd, m_cmd[mdl_owner]);
      cmp("s_addr", s_addr, m_addr[mdl_owner*AW +: AW]);
      cmp("s_wdata", s_wdata, m_wdata[mdl_owner*DW +: DW]);
    end
  end

  // ---------------- stimulus ----------------
  initial begin : driver
    logic [N-1:0] acked;
    int gq[$];
    logic prev_sreq;

    // Reset state
    @(negedge clk); #3;
    cmp("rst_sreq", s_req, 0);
    cmp("rst_ack", m_ack, 0);
    cmp("rst_gid", grant_id, 0);

    // 1: single write from m0, slave acks on the 3rd REQ cycle
    @(negedge clk); rst = 1'b0; set_m(0, 1'b1, 32'h10, 32'hA5); m_req = 3'b001; #3;
    cmp("t1_latency", s_req, 0);
    @(negedge clk); #3;
    cmp("t1_sreq", s_req, 1);
    cmp("t1_addr", s_addr, 32'h10);
    cmp("t1_wdata", s_wdata, 32'hA5);
    cmp("t1_cmd", s_cmd, 1);
    cmp("t1_gid", grant_id, 0);
    @(negedge clk); #3;
    cmp("t1_sreq2", s_req, 1);
    cmp("t1_noack", m_ack, 0);
    @(negedge clk); s_ack = 1'b1; #3;
    cmp("t1_ack", m_ack, 3'b001);
    cmp("t1_err", m_err, 0);
    cmp("t1_sreq3", s_req, 1);
    @(negedge clk); s_ack = 1'b0; m_req = '0; #3;
    cmp("t1_sreq_end", s_req, 0);

    // 2: read from m1, data on the 3rd cycle after ack
    @(negedge clk); set_m(1, 1'b0, 32'h20, 32'h0); m_req = 3'b010; #3;
    @(negedge clk); s_ack = 1'b1; #3;
    cmp("t2_ack", m_ack, 3'b010);
    cmp("t2_gid", grant_id, 1);
    @(negedge clk); s_ack = 1'b0; m_req = '0; s_rdata = 32'h9; #3;
    cmp("t2_sreq_resp", s_req, 0);
    cmp("t2_rdata_live", m_rdata, 32'h9);
    cmp("t2_noresp", m_resp, 0);
    @(negedge clk); #3;
    @(negedge clk); s_resp = 1'b1; s_rdata = 32'h1234; #3;
    cmp("t2_resp", m_resp, 3'b010);
    cmp("t2_rdata", m_rdata, 32'h1234);
    cmp("t2_err", m_err, 0);
    @(negedge clk); s_resp = 1'b0; s_rdata = '0; #3;
    cmp("t2_rdata_idle", m_rdata, 0);

    // 3: m0 and m1 contend continuously; slave acks at once
    set_m(0, 1'b1, 32'h100, 32'h1); set_m(1, 1'b1, 32'h200, 32'h2);
    acked = '0; prev_sreq = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      m_req[0] = !acked[0]; m_req[1] = !acked[1]; s_ack = 1'b1;
      #3;
      if (s_req) begin
        gq.push_back(int'(grant_id));
        cmp("t3_gap", prev_sreq, 0);
      end
      prev_sreq = s_req;
      acked = m_ack;
    end
    cmp("t3_count", gq.size() >= 4, 1);
    for (int k = 0; k < 4 && k < gq.size(); k++) cmp("t3_order", gq[k], k % 2);
    @(negedge clk); m_req = '0; s_ack = 1'b0; #3;

    // 4: write timeout, then read timeout
    @(negedge clk); set_m(0, 1'b1, 32'h40, 32'h4); m_req = 3'b001; #3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #3;
      cmp("t4_noack", m_ack, 0);
    end
    @(negedge clk); #3;
    cmp("t4_tmo_ack", m_ack, 3'b001);
    cmp("t4_tmo_err", m_err, 3'b001);
    @(negedge clk); m_req = '0; #3;
    cmp("t4_idle", s_req, 0);
    @(negedge clk); set_m(0, 1'b0, 32'h44, 32'h0); m_req = 3'b001; #3;
    @(negedge clk); s_ack = 1'b1; #3;
    cmp("t4_rd_ack", m_ack, 3'b001);
    @(negedge clk); s_ack = 1'b0; m_req = '0; s_rdata = 32'h5555; #3;
    cmp("t4_rd_live", m_rdata, 32'h5555);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #3;
      cmp("t4_rd_noresp", m_resp, 0);
    end
    @(negedge clk); #3;
    cmp("t4_rd_tmo_resp", m_resp, 3'b001);
    cmp("t4_rd_tmo_err", m_err, 3'b001);
    cmp("t4_rd_tmo_data", m_rdata, 0);
    @(negedge clk); s_rdata = '0; #3;

    // 5a: ack landing in the timeout cycle wins
    @(negedge clk); set_m(0, 1'b1, 32'h50, 32'h5); m_req = 3'b001; #3;
    repeat (3) @(negedge clk);
    @(negedge clk); s_ack = 1'b1; #3;
    cmp("t5_ack", m_ack, 3'b001);
    cmp("t5_noerr", m_err, 0);
    @(negedge clk); s_ack = 1'b0; m_req = '0; #3;

    // 5b: reset during RESP is silent, next grant goes to m0
    @(negedge clk); set_m(1, 1'b0, 32'h60, 32'h0); m_req = 3'b010; #3;
    @(negedge clk); s_ack = 1'b1; #3;
    cmp("t5_rd_ack", m_ack, 3'b010);
    @(negedge clk); s_ack = 1'b0; m_req = '0; #3;
    @(negedge clk); rst = 1'b1; s_resp = 1'b1; s_rdata = 32'h77; #3;
    cmp("t5_rst_noresp", m_resp, 0);
    cmp("t5_rst_rdata", m_rdata, 0);
    @(negedge clk); rst = 1'b0; s_resp = 1'b0; s_rdata = '0;
    set_m(0, 1'b1, 32'h70, 32'h7); set_m(1, 1'b1, 32'h80, 32'h8); m_req = 3'b011; #3;
    @(negedge clk); #3;
    cmp("t5_after_rst_gid", grant_id, 0);
    cmp("t5_after_rst_sreq", s_req, 1);
    @(negedge clk); s_ack = 1'b1; #3;
    cmp("t5_after_rst_ack", m_ack, 3'b001);
    @(negedge clk); s_ack = 1'b0; m_req = '0; #3;

    // Random phase: protocol-abiding masters, erratic slave, rare resets
    acked = '0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) begin
        if (acked[i]) begin
          m_req[i] = 1'b0;
        end else if (!m_req[i] && $urandom_range(0, 2) == 0) begin
          set_m(i, 1'($urandom), AW'($urandom), DW'($urandom));
          m_req[i] = 1'b1;
        end
      end
      s_ack   = ($urandom_range(0, 99) < 35);
      s_resp  = ($urandom_range(0, 99) < 35);
      s_rdata = DW'($urandom);
      #1;
      acked = m_ack;
    end
    @(negedge clk); m_req = '0; s_ack = 1'b0; s_resp = 1'b0; rst = 1'b0;
    @(negedge clk); #3;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
